// File: rtl/hsv_core_wb_arbiter.sv
// ----------------------------------------------------------------------------
// hsv_core_wb_arbiter
//
// Purpose:
//   Shares the single issue-stage regfile write port among the exec-mem units
//   (0=ALU, 1=branch, 2=ctrl-status, 3=mem). Round-robin arbitration picks
//   at most one result per cycle. The accepted result appears on the
//   registered write port one cycle later, together with a one-hot
//   register-mask clear pulse so the masking stage can release the rd hazard.
//
// Handshake (valid/ready):
//   A unit's result transfers on a clock edge where req_valid_i[i] and
//   req_ready_o[i] are both high. Once valid is raised, the unit holds valid,
//   addr and data stable until that edge. req_ready_o depends only on
//   req_valid_i, the round-robin pointer and flush_req. There is no
//   downstream backpressure: the regfile always accepts.
//
// Ports:
//   clk_core     in   1                  core clock
//   rst_core_n   in   1                  async active-low reset
//   flush_req    in   1                  pipeline flush request
//   flush_ack    out  1                  registered echo of flush_req
//   req_valid_i  in   NUM_UNITS          unit i has a result to write
//   req_ready_o  out  NUM_UNITS          unit i result accepted this cycle
//   req_addr_i   in   NUM_UNITS*ADDR_W   rd of unit i, slice [i*ADDR_W +: ADDR_W]
//   req_data_i   in   NUM_UNITS*DATA_W   result of unit i, slice [i*DATA_W +: DATA_W]
//   wr_addr      out  ADDR_W             regfile write address
//   wr_data      out  DATA_W             regfile write data
//   wr_en        out  1                  regfile write enable (never for x0)
//   clr_mask     out  2**ADDR_W          one-hot rd mask release, same cycle as wr_en
//   grant_o      out  NUM_UNITS          one-hot winner this cycle (debug/cover)
// ----------------------------------------------------------------------------
module hsv_core_wb_arbiter #(
    parameter int NUM_UNITS = 4,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32
) (
    input  logic                          clk_core,
    input  logic                          rst_core_n,
    input  logic                          flush_req,
    output logic                          flush_ack,
    input  logic [NUM_UNITS-1:0]          req_valid_i,
    output logic [NUM_UNITS-1:0]          req_ready_o,
    input  logic [NUM_UNITS*ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_UNITS*DATA_W-1:0]   req_data_i,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [DATA_W-1:0]             wr_data,
    output logic                          wr_en,
    output logic [(2**ADDR_W)-1:0]        clr_mask,
    output logic [NUM_UNITS-1:0]          grant_o
);

    localparam int PTR_W  = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int MASK_W = 2**ADDR_W;

    // Round-robin pointer: the unit with highest priority this cycle.
    logic [PTR_W-1:0]     r_ptr;
    logic                 r_flush_ack;
    logic [ADDR_W-1:0]    r_wr_addr;
    logic [DATA_W-1:0]    r_wr_data;
    logic                 r_wr_en;
    logic [MASK_W-1:0]    r_clr_mask;

    logic                 w_found;
    logic [PTR_W-1:0]     w_win_idx;
    logic [PTR_W:0]       w_sum;
    logic [NUM_UNITS-1:0] w_grant;
    logic [ADDR_W-1:0]    w_win_addr;
    logic [DATA_W-1:0]    w_win_data;
    logic [PTR_W-1:0]     w_next_ptr;

    // Search from r_ptr upward, wrapping modulo NUM_UNITS. The one-bit-wider
    // sum lets the wrap work for non-power-of-two unit counts.
    always_comb begin
        w_found   = 1'b0;
        w_win_idx = '0;
        w_sum     = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (w_sum >= (PTR_W+1)'(NUM_UNITS)) begin
                w_sum = w_sum - (PTR_W+1)'(NUM_UNITS);
            end
            if (!w_found && req_valid_i[w_sum[PTR_W-1:0]]) begin
                w_found   = 1'b1;
                w_win_idx = w_sum[PTR_W-1:0];
            end
        end
        // A flush blocks all grants so nothing younger than the flush
        // point reaches the regfile.
        if (flush_req) begin
            w_found = 1'b0;
        end
    end

    always_comb begin
        w_grant = '0;
        if (w_found) begin
            w_grant[w_win_idx] = 1'b1;
        end
    end

    // Winner payload mux, driven by the one-hot grant.
    always_comb begin
        w_win_addr = '0;
        w_win_data = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (w_grant[i]) begin
                w_win_addr = req_addr_i[i*ADDR_W +: ADDR_W];
                w_win_data = req_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_next_ptr = (w_win_idx == PTR_W'(NUM_UNITS-1)) ? '0 : (w_win_idx + PTR_W'(1));

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            r_ptr       <= '0;
            r_flush_ack <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_wr_en     <= 1'b0;
            r_clr_mask  <= '0;
        end else begin
            r_flush_ack <= flush_req;

            if (flush_req) begin
                r_ptr <= '0;
            end else if (w_found) begin
                r_ptr <= w_next_ptr;
            end

            if (w_found) begin
                r_wr_addr <= w_win_addr;
                r_wr_data <= w_win_data;
                // x0 is hardwired zero: the transfer completes but neither
                // the regfile write nor the mask release fires.
                if (w_win_addr != '0) begin
                    r_wr_en    <= 1'b1;
                    r_clr_mask <= MASK_W'(1) << w_win_addr;
                end else begin
                    r_wr_en    <= 1'b0;
                    r_clr_mask <= '0;
                end
            end else begin
                r_wr_en    <= 1'b0;
                r_clr_mask <= '0;
            end
        end
    end

    assign req_ready_o = w_grant;
    assign grant_o     = w_grant;
    assign flush_ack   = r_flush_ack;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign wr_en       = r_wr_en;
    assign clr_mask    = r_clr_mask;

endmodule
